// File: rtl/imem_port_arbiter_pkg.sv
// Shared encodings and helpers for the unified memory port arbiter.
// Imported by the arbiter top and its winner-select sub-module.
package imem_port_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_ISSUE = 2'd1;
  localparam logic [1:0] ARB_WAIT  = 2'd2;

  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_FETCH = 2'd1;
  localparam logic [1:0] OWN_LSU   = 2'd2;

  localparam logic [3:0] BE_WORD   = 4'hF;

  function automatic logic [3:0] starve_next(
    input logic [3:0] cnt,
    input logic [3:0] lim
  );
    return (cnt >= lim) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, LSU and memory bus bundle for the unified port arbiter.
// slave = arbiter side, master = pipeline/memory side.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              fetch_req_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              fetch_gnt_o;
  logic              fetch_rvalid_o;
  logic [DATA_W-1:0] fetch_rdata_o;

  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [3:0]        lsu_be_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [DATA_W-1:0] lsu_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i,
    output fetch_gnt_o, fetch_rvalid_o,
    output fetch_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_be_i,
    input  lsu_addr_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o,
    output lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o,
    output mem_addr_o, mem_wdata_o,
    input  mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output fetch_req_i, fetch_addr_i,
    input  fetch_gnt_o, fetch_rvalid_o,
    input  fetch_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_be_i,
    output lsu_addr_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o,
    input  lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o,
    input  mem_addr_o, mem_wdata_o,
    output mem_rvalid_i, mem_rdata_i
  );

endinterface

// File: rtl/imem_port_arbiter_starve_select.sv
// Winner choice between fetch and LSU, plus the fetch starvation counter.
// LSU wins ties until fetch has lost STARVE_LIMIT arbitrations in a row.
module arb_starve_select
  import imem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic arb_en,
  input  logic fetch_req,
  input  logic lsu_req,
  output logic pick_fetch,
  output logic pick_lsu
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved    = (starve_cnt == LIMIT);
  assign pick_fetch = fetch_req & (~lsu_req | starved);
  assign pick_lsu   = lsu_req & ~pick_fetch;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      starve_cnt <= 4'd0;
    end else if (arb_en) begin
      if (pick_fetch) begin
        starve_cnt <= 4'd0;
      end else if (fetch_req) begin
        starve_cnt <= starve_next(starve_cnt, LIMIT);
      end
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one memory port between fetch and LSU, one registered
// transaction at a time, with flush squash and a WAIT timeout.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  imem_port_arbiter_if.slave bus,
  output logic timeout_o
);

  localparam int WCW = $clog2(TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  logic [1:0]        state;
  logic [1:0]        owner;
  logic              own_we;
  logic              squash;
  logic [WCW-1:0]    wait_cnt;
  logic              arb_en;
  logic              fetch_act;
  logic              pick_fetch;
  logic              pick_lsu;
  logic              drop_f;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] rdata;

  assign arb_en    = (state == ARB_IDLE);
  // a flush in the arbitration cycle withdraws the fetch request
  assign fetch_act = bus.fetch_req_i & ~flush_i;
  assign drop_f    = squash | flush_i;
  assign f_addr    = bus.fetch_addr_i;
  assign rdata     = bus.mem_rdata_i;

  arb_starve_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .arb_en    (arb_en),
    .fetch_req (fetch_act),
    .lsu_req   (bus.lsu_req_i),
    .pick_fetch(pick_fetch),
    .pick_lsu  (pick_lsu)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state              <= ARB_IDLE;
      owner              <= OWN_NONE;
      own_we             <= 1'b0;
      squash             <= 1'b0;
      wait_cnt           <= '0;
      timeout_o          <= 1'b0;
      bus.fetch_gnt_o    <= 1'b0;
      bus.fetch_rvalid_o <= 1'b0;
      bus.fetch_rdata_o  <= '0;
      bus.lsu_gnt_o      <= 1'b0;
      bus.lsu_rvalid_o   <= 1'b0;
      bus.lsu_rdata_o    <= '0;
      bus.mem_req_o      <= 1'b0;
      bus.mem_we_o       <= 1'b0;
      bus.mem_be_o       <= 4'd0;
      bus.mem_addr_o     <= '0;
      bus.mem_wdata_o    <= '0;
    end else begin
      timeout_o          <= 1'b0;
      bus.fetch_gnt_o    <= 1'b0;
      bus.fetch_rvalid_o <= 1'b0;
      bus.lsu_gnt_o      <= 1'b0;
      bus.lsu_rvalid_o   <= 1'b0;
      bus.mem_req_o      <= 1'b0;
      bus.mem_we_o       <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          squash <= 1'b0;
          unique case (1'b1)
            pick_fetch: begin
              state           <= ARB_ISSUE;
              owner           <= OWN_FETCH;
              own_we          <= 1'b0;
              bus.fetch_gnt_o <= 1'b1;
              bus.mem_req_o   <= 1'b1;
              bus.mem_be_o    <= BE_WORD;
              bus.mem_addr_o  <= f_addr;
            end
            pick_lsu: begin
              state           <= ARB_ISSUE;
              owner           <= OWN_LSU;
              own_we          <= bus.lsu_we_i;
              bus.lsu_gnt_o   <= 1'b1;
              bus.mem_req_o   <= 1'b1;
              bus.mem_we_o    <= bus.lsu_we_i;
              bus.mem_be_o    <= bus.lsu_be_i;
              bus.mem_addr_o  <= bus.lsu_addr_i;
              bus.mem_wdata_o <= bus.lsu_wdata_i;
            end
            default: owner <= OWN_NONE;
          endcase
        end
        ARB_ISSUE: begin
          state    <= ARB_WAIT;
          wait_cnt <= '0;
          if (flush_i && owner == OWN_FETCH) squash <= 1'b1;
        end
        ARB_WAIT: begin
          if (flush_i && owner == OWN_FETCH) squash <= 1'b1;
          if (bus.mem_rvalid_i) begin
            state <= ARB_IDLE;
            owner <= OWN_NONE;
            if (owner == OWN_FETCH) begin
              if (!drop_f) begin
                bus.fetch_rvalid_o <= 1'b1;
                bus.fetch_rdata_o  <= rdata;
              end
            end else begin
              bus.lsu_rvalid_o <= 1'b1;
              if (!own_we) bus.lsu_rdata_o <= rdata;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ARB_IDLE;
            owner     <= OWN_NONE;
            timeout_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: begin
          state <= ARB_IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule
